// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_pkg
// Purpose  : Glyph table, glyph decoder and settle-FSM state encoding shared
//            by the seven-segment scan decoder.
// Revision : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } settle_state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] nibble;
    } glyph_t;

    // Active-low cathode patterns {g,f,e,d,c,b,a}, indexed by hex value.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic glyph_t glyph_decode(input logic [6:0] seg);
        glyph_t r;
        r.legal  = 1'b0;
        r.nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPH_TABLE[i]) begin
                r.legal  = 1'b1;
                r.nibble = 4'(i);
            end
        end
        return r;
    endfunction

    function automatic logic multi_low(input logic [7:0] an);
        logic [7:0] low;
        low = ~an;
        return |(low & (low - 8'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_settle.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_settle
// Purpose  : Synchronises the observed scan and strobes once per pattern that
//            has stayed stable for SETTLE_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_settle
    import sevenseg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] an_i,
    input  logic [6:0] seg_i,
    output logic       eval_o,
    output logic [7:0] an_o,
    output logic [6:0] seg_o,
    output logic       an_active_o
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_THRESH = CNT_W'(SETTLE_CYCLES - 1);

    logic [7:0]       an_s1_q, an_s2_q;
    logic [6:0]       seg_s1_q, seg_s2_q;
    logic [14:0]      pat_q;
    logic [CNT_W-1:0] cnt_q;
    logic             eval_q;
    settle_state_t    state_q;
    logic [14:0]      w_pat;

    assign w_pat = {an_s2_q, seg_s2_q};

    // The entry cycle counts as the first stable cycle, so pat_q is compared
    // against the live pattern from then on.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            an_s1_q  <= '1;
            an_s2_q  <= '1;
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            pat_q    <= '1;
            cnt_q    <= '0;
            eval_q   <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            an_s1_q  <= an_i;
            an_s2_q  <= an_s1_q;
            seg_s1_q <= seg_i;
            seg_s2_q <= seg_s1_q;
            eval_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!(&an_s2_q)) begin
                        state_q <= ST_SETTLE;
                        pat_q   <= w_pat;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (&an_s2_q) begin
                        state_q <= ST_IDLE;
                    end else if (w_pat != pat_q) begin
                        pat_q <= w_pat;
                        cnt_q <= CNT_W'(1);
                    end else if (cnt_q >= C_THRESH) begin
                        eval_q  <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (&an_s2_q) begin
                        state_q <= ST_IDLE;
                    end else if (w_pat != pat_q) begin
                        state_q <= ST_SETTLE;
                        pat_q   <= w_pat;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign eval_o      = eval_q;
    assign an_o        = pat_q[14:7];
    assign seg_o       = pat_q[6:0];
    assign an_active_o = ~(&an_s2_q);

endmodule
`default_nettype wire

// File: rtl/sevenseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_scan_decoder
// Purpose  : Recovers the hex value shown on a scanned 8-digit display and
//            reports frames, glyph/anode errors and a stale scan.
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [7:0]  AN,
    input  logic [6:0]  segment,
    output logic [31:0] digit_value,
    output logic [7:0]  digit_seen,
    output logic [31:0] frame_value,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        seg_error,
    output logic        an_error,
    output logic        stale
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] C_TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic        w_eval, w_an_active, w_multi, w_capture;
    logic [7:0]  w_an_st;
    logic [6:0]  w_seg_st;
    glyph_t      w_glyph;
    logic [31:0] value_q, value_d, frame_value_q;
    logic [7:0]  seen_q, seen_d;
    logic        frame_valid_q, frame_changed_q, have_frame_q;
    logic        seg_err_q, an_err_q, stale_q;
    logic [TO_W-1:0] idle_cnt_q;

    sevenseg_settle #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk_i       (CLK100MHZ),
        .rst_ni      (CPU_RESETN),
        .an_i        (AN),
        .seg_i       (segment),
        .eval_o      (w_eval),
        .an_o        (w_an_st),
        .seg_o       (w_seg_st),
        .an_active_o (w_an_active)
    );

    assign w_glyph   = glyph_decode(w_seg_st);
    assign w_multi   = multi_low(w_an_st);
    assign w_capture = w_eval && !w_multi && w_glyph.legal;

    // A capture landing on the frame-clear cycle starts the next frame.
    always_comb begin
        value_d = value_q;
        seen_d  = seen_q;
        if (&seen_q) seen_d = '0;
        if (w_capture) begin
            seen_d = seen_d | ~w_an_st;
            for (int i = 0; i < 8; i++) begin
                if (!w_an_st[i]) value_d[4*i +: 4] = w_glyph.nibble;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            value_q         <= '0;
            seen_q          <= '0;
            frame_value_q   <= '0;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            have_frame_q    <= 1'b0;
            seg_err_q       <= 1'b0;
            an_err_q        <= 1'b0;
            stale_q         <= 1'b0;
            idle_cnt_q      <= '0;
        end else begin
            value_q         <= value_d;
            seen_q          <= seen_d;
            seg_err_q       <= w_eval && !w_multi && !w_glyph.legal;
            an_err_q        <= w_eval && w_multi;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            if (&seen_q) begin
                frame_value_q   <= value_q;
                frame_valid_q   <= 1'b1;
                frame_changed_q <= have_frame_q && (value_q != frame_value_q);
                have_frame_q    <= 1'b1;
            end
            if (w_an_active) begin
                idle_cnt_q <= '0;
                stale_q    <= 1'b0;
            end else begin
                if (idle_cnt_q != C_TO_MAX) idle_cnt_q <= idle_cnt_q + TO_W'(1);
                if (idle_cnt_q >= C_TO_LAST) stale_q <= 1'b1;
            end
        end
    end

    assign digit_value   = value_q;
    assign digit_seen    = seen_q;
    assign frame_value   = frame_value_q;
    assign frame_valid   = frame_valid_q;
    assign frame_changed = frame_changed_q;
    assign seg_error     = seg_err_q;
    assign an_error      = an_err_q;
    assign stale         = stale_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_scan_decoder
// Purpose  : Directed scoreboard bench for the seven-segment scan decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan_decoder;

    localparam int TIMEOUT = 64;
    localparam logic [2:0] K_FRAME = 3'b100;
    localparam logic [2:0] K_AN    = 3'b010;
    localparam logic [2:0] K_SEG   = 3'b001;
    localparam logic [6:0] GLY [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] val;
        logic        chg;
        logic [7:0]  seen;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  an = 8'hFF;
    logic [6:0]  seg = 7'h7F;
    logic [31:0] digit_value, frame_value;
    logic [7:0]  digit_seen;
    logic        frame_valid, frame_changed, seg_error, an_error, stale;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    sevenseg_scan_decoder #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLK100MHZ     (clk),
        .CPU_RESETN    (rst_n),
        .AN            (an),
        .segment       (seg),
        .digit_value   (digit_value),
        .digit_seen    (digit_seen),
        .frame_value   (frame_value),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .seg_error     (seg_error),
        .an_error      (an_error),
        .stale         (stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic show(input logic [7:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan_frame(input logic [31:0] v, input int hold);
        logic [31:0] vv;
        vv = v;
        for (int i = 0; i < 8; i++) show(~(8'h01 << i), GLY[vv[4*i +: 4]], hold);
    endtask

    task automatic expect_evt(input logic [2:0] k, input logic [31:0] v,
                              input logic c, input logic [7:0] s);
        exp_t e;
        e.kind = k; e.val = v; e.chg = c; e.seen = s;
        sb.push_back(e);
    endtask

    // Monitor: every pulse on the event outputs must match the oldest expectation.
    always @(negedge clk) begin : monitor
        logic [2:0] k;
        exp_t e;
        k = {frame_valid, an_error, seg_error};
        if (rst_n && k != 3'b000) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: got kind %b, expected none", k);
            end else begin
                e = sb.pop_front();
                chk("event_kind", 32'(k), 32'(e.kind));
                if (e.kind == K_FRAME) begin
                    chk("frame_value", frame_value, e.val);
                    chk("frame_changed", 32'(frame_changed), 32'(e.chg));
                end else begin
                    chk("err_digit_value", digit_value, e.val);
                end
                chk("event_digit_seen", 32'(digit_seen), 32'(e.seen));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digit_value", digit_value, 32'h0);
        chk("rst_digit_seen", 32'(digit_seen), 32'h0);
        chk("rst_frame_value", frame_value, 32'h0);
        chk("rst_pulses", 32'({frame_valid, frame_changed, seg_error, an_error}), 32'h0);
        chk("rst_stale", 32'(stale), 32'h0);

        // Clean scans: first frame, repeat frame, then digit 3 changes to A.
        expect_evt(K_FRAME, 32'h76543210, 1'b0, 8'h00);
        scan_frame(32'h76543210, 20);
        expect_evt(K_FRAME, 32'h76543210, 1'b0, 8'h00);
        scan_frame(32'h76543210, 20);
        expect_evt(K_FRAME, 32'h7654A210, 1'b1, 8'h00);
        scan_frame(32'h7654A210, 20);
        show(8'hFF, 7'h7F, 10);
        chk("post_frame_seen", 32'(digit_seen), 32'h0);

        // Glitch rejection: 3 stable cycles is too short, 4 is enough.
        show(8'hFE, GLY[5], 3);
        show(8'hFF, 7'h7F, 10);
        chk("glitch_seen", 32'(digit_seen), 32'h0);
        chk("glitch_value", digit_value, 32'h7654A210);
        show(8'hFE, GLY[5], 4);
        show(8'hFF, 7'h7F, 10);
        chk("settled_seen", 32'(digit_seen), 32'h01);
        chk("settled_value", digit_value, 32'h7654A215);

        // Illegal glyph, two anodes, then both faults at once.
        expect_evt(K_SEG, 32'h7654A215, 1'b0, 8'h01);
        show(8'hFE, 7'h7F, 10);
        show(8'hFF, 7'h7F, 5);
        expect_evt(K_AN, 32'h7654A215, 1'b0, 8'h01);
        show(8'hFC, GLY[1], 10);
        show(8'hFF, 7'h7F, 5);
        expect_evt(K_AN, 32'h7654A215, 1'b0, 8'h01);
        show(8'hF3, 7'h7F, 10);
        show(8'hFF, 7'h7F, 5);
        chk("errors_value", digit_value, 32'h7654A215);

        // Re-capture of a seen position overwrites without completing a frame.
        show(8'hFE, GLY[9], 10);
        show(8'hFF, 7'h7F, 5);
        chk("recap_seen", 32'(digit_seen), 32'h01);
        chk("recap_value", digit_value, 32'h7654A219);
        expect_evt(K_FRAME, 32'h7654A219, 1'b1, 8'h00);
        scan_frame(32'h7654A219, 20);

        // Stale: below the limit stays low, past it goes high, an anode clears it.
        show(8'hFF, 7'h7F, 50);
        chk("stale_early", 32'(stale), 32'h0);
        show(8'hFF, 7'h7F, 30);
        chk("stale_set", 32'(stale), 32'h1);
        show(8'hFE, GLY[0], 4);
        chk("stale_cleared", 32'(stale), 32'h0);

        // Mid-frame reset discards the partial frame.
        show(8'hFE, GLY[0], 16);
        show(8'hFD, GLY[1], 20);
        chk("partial_seen", 32'(digit_seen), 32'h03);
        show(8'hFB, GLY[2], 5);
        rst_n = 1'b0;
        #2;
        chk("midrst_value", digit_value, 32'h0);
        chk("midrst_seen", 32'(digit_seen), 32'h0);
        chk("midrst_frame", frame_value, 32'h0);
        chk("midrst_flags", 32'({frame_valid, frame_changed, seg_error, an_error, stale}), 32'h0);
        an = 8'hFF;
        seg = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        show(8'hFF, 7'h7F, 10);
        chk("after_rst_seen", 32'(digit_seen), 32'h0);
        chk("after_rst_value", digit_value, 32'h0);

        // First frame after reset never reports a change.
        expect_evt(K_FRAME, 32'h7654A210, 1'b0, 8'h00);
        scan_frame(32'h7654A210, 20);
        show(8'hFF, 7'h7F, 10);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sevenseg_scan_decoder.md
SEVENSEG_SCAN_DECODER -- requirements
Module: sevenseg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, the cycles a pattern must hold stable before capture.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576, the idle cycles before the scan is declared stale.
REQ-003 SHALL have port CLK100MHZ, input, 1 bit, the single system clock; there is one clock only.
REQ-004 SHALL have port CPU_RESETN, input, 1 bit, reset, asynchronous and active-low.
REQ-005 SHALL have port AN, input, 8 bits, observed digit anodes, active-low, one-hot-low during a valid scan.
REQ-006 SHALL have port segment, input, 7 bits, observed cathodes {g,f,e,d,c,b,a}, active-low.
REQ-007 SHALL have port digit_value, output, 32 bits, the last captured nibble per position; nibble i is AN[i].
REQ-008 SHALL have port digit_seen, output, 8 bits, positions captured since the last frame.
REQ-009 SHALL have port frame_value, output, 32 bits, the value of the last completed frame.
REQ-010 SHALL have port frame_valid, output, 1 bit, a one-cycle pulse on frame completion.
REQ-011 SHALL have port frame_changed, output, 1 bit, a one-cycle pulse coincident with frame_valid when frame_value differs from the prior frame.
REQ-012 SHALL have port seg_error, output, 1 bit, a one-cycle pulse when a settled pattern is not a legal hex glyph.
REQ-013 SHALL have port an_error, output, 1 bit, a one-cycle pulse when more than one anode is settled low.
REQ-014 SHALL have port stale, output, 1 bit, a level that is high while no anode has been active for TIMEOUT_CYCLES.

Function
REQ-015 SHALL register AN and segment through two flops before any use; all latencies below count from the second flop's output.
REQ-016 SHALL implement FSM IDLE/SETTLE/HOLD:
- IDLE to SETTLE when any AN bit is low.
- SETTLE counts while {AN,segment} is unchanged and restarts the count on any change.
- SETTLE to IDLE when AN is all-high.
- When the count reaches SETTLE_CYCLES: evaluate, then go to HOLD.
- HOLD to SETTLE on any {AN,segment} change; HOLD to IDLE when AN is all-high.
REQ-017 SHALL decode legal glyphs (hex, active-low) as follows: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-018 SHALL handle a legal glyph with one anode low on the evaluate cycle by updating that nibble of digit_value and setting that bit of digit_seen on the next cycle.
REQ-019 SHALL handle an illegal glyph by pulsing seg_error for one cycle, with no update to digit_value or digit_seen.
REQ-020 SHALL handle two or more anodes low by pulsing an_error for one cycle, with no update; when a pattern has both errors, only an_error pulses.
REQ-021 SHALL complete a frame on the cycle after digit_seen becomes all-ones:
- frame_value loads digit_value.
- frame_valid pulses.
- frame_changed pulses if the new value differs from the old.
- digit_seen clears to 0.
REQ-022 SHALL merge a capture that coincides with a frame clear into the new frame, so that bit is set after the clear.
REQ-023 SHALL treat a re-capture of an already-seen position within a frame as overwriting the nibble without completing a frame.
REQ-024 SHALL raise stale when the idle counter reaches TIMEOUT_CYCLES and hold it high; any anode low clears stale and the counter on the next cycle; the counter saturates.
REQ-025 SHALL suppress frame_changed on the first frame after reset.

Reset
REQ-026 SHALL, on CPU_RESETN low, asynchronously reset:
- FSM to IDLE.
- Synchronizers to all-ones.
- digit_value, digit_seen and frame_value to 0.
- All pulses low, stale low.
- Counters to 0.
REQ-027 SHALL, on reset assertion mid-frame, discard the partial frame; no frame_valid is produced for that frame.

Structure
REQ-028 SHALL place the glyph table, the decode function and the state enum in package sevenseg_pkg.
REQ-029 SHALL place the settle logic (synchronizer, stability counter, FSM) in sub-module sevenseg_settle, which emits a one-cycle evaluate strobe plus the stable AN and segment.

Verification
REQ-030 SHALL cover a clean scan: AN cycles FE..7F, each held 20 cycles, digits 0..7 -> frame_valid once, frame_value=76543210.
REQ-031 SHALL cover glitch rejection: pattern held 3 cycles then changed -> no capture; held at least 4 cycles -> capture.
REQ-032 SHALL cover an illegal glyph: segment=7F (blank) with AN=FE -> seg_error pulses once; nibble 0 unchanged.
REQ-033 SHALL cover two anodes: AN=FC -> an_error pulses once; digit_seen unchanged.
REQ-034 SHALL cover frame change: a repeat frame 76543210 -> frame_changed=0; then digit 3 changes to A -> frame_changed=1 with frame_value=7654A210.
REQ-035 SHALL cover timeout and reset: AN=FF for TIMEOUT_CYCLES -> stale=1; CPU_RESETN low mid-frame -> all outputs 0 and no frame_valid.
